blink_mode_ctrl: RTL and testbench



---
 rtl/blinky_pkg.sv | 18 +
 rtl/btn_debounce.sv | 67 ++++++
 rtl/blink_mode_ctrl.sv | 114 +++++++++++
 tb/tb_blink_mode_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/blinky_pkg.sv
// rtl/blinky_pkg.sv - shared mode type, clock constant and helpers for the blinky LED controller
package blinky_pkg;

  // Board system clock; parameter defaults are derived from it.
  localparam int CLK_HZ = 100_000_000;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_SLOW = 2'd1,
    MODE_FAST = 2'd2,
    MODE_ON   = 2'd3
  } blink_mode_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchronizer, debouncer and press-edge pulse generator
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q, stable_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Two-flop synchronizer, debounce counter and rising-edge detect of the accepted level.
  // Any sample that agrees with the accepted level restarts the count, so only an
  // unbroken run of DEBOUNCE_CYCLES disagreeing samples flips the level.
  always_comb begin
    s1_d         = btn;
    s2_d         = s1_q;
    stable_d     = stable_q;
    cnt_d        = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    stable_dly_d = stable_q;
    press_d      = stable_q & ~stable_dly_q;
  end

  // State registers with synchronous reset; a reset discards any debounce in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
    end
  end

  assign level = stable_q;
  assign press = press_q;

endmodule

// File: rtl/blink_mode_ctrl.sv
// rtl/blink_mode_ctrl.sv - button-stepped OFF/SLOW/FAST/ON LED blink controller
module blink_mode_ctrl
  import blinky_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = CLK_HZ / 100,
  parameter int SLOW_HALF       = CLK_HZ / 2,
  parameter int FAST_HALF       = CLK_HZ / 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       led,
  output logic [1:0] mode,
  output logic       press
);

  localparam int PCNT_W = $clog2(max_int(SLOW_HALF, FAST_HALF));
  localparam logic [PCNT_W-1:0] SLOW_LAST = PCNT_W'(SLOW_HALF - 1);
  localparam logic [PCNT_W-1:0] FAST_LAST = PCNT_W'(FAST_HALF - 1);

  if (SLOW_HALF < 2) begin : g_bad_slow
    $error("blink_mode_ctrl: SLOW_HALF must be >= 2");
  end
  if (FAST_HALF < 2) begin : g_bad_fast
    $error("blink_mode_ctrl: FAST_HALF must be >= 2");
  end

  logic              press_w;
  logic              level_unused;
  blink_mode_t       mode_q, mode_d;
  logic              phase_q, phase_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [PCNT_W-1:0] half_last;
  logic              led_q, led_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .level(level_unused),
    .press(press_w)
  );

  // Mode state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_OFF;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Mode next state: each accepted press steps to the next mode, wrapping ON back to OFF.
  always_comb begin
    mode_d = mode_q;
    if (press_w) begin
      case (mode_q)
        MODE_OFF:  mode_d = MODE_SLOW;
        MODE_SLOW: mode_d = MODE_FAST;
        MODE_FAST: mode_d = MODE_ON;
        MODE_ON:   mode_d = MODE_OFF;
        default:   mode_d = MODE_OFF;
      endcase
    end
  end

  // LED drive decode: OFF dark, ON lit, blink modes follow the phase.
  always_comb begin
    led_d = 1'b0;
    case (mode_q)
      MODE_OFF:  led_d = 1'b0;
      MODE_ON:   led_d = 1'b1;
      MODE_SLOW: led_d = phase_q;
      MODE_FAST: led_d = phase_q;
      default:   led_d = 1'b0;
    endcase
  end

  // Blink engine: half-period counter and phase. A mode change has priority over a
  // coincident wrap so every new mode starts lit with a full half-period.
  always_comb begin
    half_last = (mode_q == MODE_SLOW) ? SLOW_LAST : FAST_LAST;
    pcnt_d    = '0;
    phase_d   = 1'b1;
    if (!press_w && (mode_q == MODE_SLOW || mode_q == MODE_FAST)) begin
      if (pcnt_q == half_last) begin
        phase_d = ~phase_q;
      end else begin
        pcnt_d  = pcnt_q + PCNT_W'(1);
        phase_d = phase_q;
      end
    end
  end

  // Blink engine and LED output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q  <= '0;
      phase_q <= 1'b1;
      led_q   <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  assign led   = led_q;
  assign mode  = mode_q;
  assign press = press_w;

endmodule

// File: tb/tb_blink_mode_ctrl.sv
// tb/tb_blink_mode_ctrl.sv - self-checking bench for blink_mode_ctrl
module tb_blink_mode_ctrl;

  typedef struct {
    int         cyc;
    logic       rst;
    logic       btn;
    logic       exp_press;
    logic [1:0] exp_mode;
    logic       exp_led;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b1;
  logic       led;
  logic [1:0] mode;
  logic       press;

  int   cyc       = 0;
  int   errors    = 0;
  int   checks    = 0;
  int   press_cnt = 0;
  int   p0;
  vec_t tv[$];
  bit   bpat[8]   = '{1, 0, 1, 1, 0, 1, 1, 1};

  blink_mode_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .SLOW_HALF      (6),
    .FAST_HALF      (2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .led  (led),
    .mode (mode),
    .press(press)
  );

  initial forever #5 clk = ~clk;

  always @(negedge clk) if (press === 1'b1) press_cnt++;

  initial begin
    #20000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic add(input int c, input logic r, input logic b,
                     input logic p, input logic [1:0] m, input logic l);
    vec_t v;
    v.cyc = c; v.rst = r; v.btn = b;
    v.exp_press = p; v.exp_mode = m; v.exp_led = l;
    tv.push_back(v);
  endtask

  initial begin
    // cycle, rst, btn (applied from this cycle), expected press, mode, led (in this cycle)
    add( 1, 1, 0, 0, 0, 0);
    add( 2, 1, 1, 0, 0, 0);
    add( 3, 0, 0, 0, 0, 0);
    add( 4, 0, 0, 0, 0, 0);
    add(10, 0, 1, 0, 0, 0);
    add(16, 0, 1, 0, 0, 0);
    add(17, 0, 1, 1, 0, 0);
    add(18, 0, 0, 0, 1, 0);
    add(19, 0, 0, 0, 1, 1);
    add(24, 0, 0, 0, 1, 1);
    add(25, 0, 0, 0, 1, 0);
    add(28, 0, 1, 0, 1, 0);
    add(30, 0, 1, 0, 1, 0);
    add(31, 0, 1, 0, 1, 1);
    add(35, 0, 1, 1, 1, 1);
    add(36, 0, 0, 0, 2, 1);
    add(37, 0, 0, 0, 2, 1);
    add(38, 0, 0, 0, 2, 1);
    add(39, 0, 0, 0, 2, 0);
    add(40, 0, 0, 0, 2, 0);
    add(41, 0, 0, 0, 2, 1);
    add(42, 0, 0, 0, 2, 1);
    add(43, 0, 0, 0, 2, 0);
    add(46, 0, 1, 0, 2, 1);
    add(53, 0, 1, 1, 2, 1);
    add(54, 0, 0, 0, 3, 1);
    add(55, 0, 0, 0, 3, 1);
    add(58, 0, 0, 0, 3, 1);
    add(62, 0, 0, 0, 3, 1);
    add(64, 0, 1, 0, 3, 1);
    add(71, 0, 1, 1, 3, 1);
    add(72, 0, 0, 0, 0, 1);
    add(73, 0, 0, 0, 0, 0);
    add(80, 0, 0, 0, 0, 0);

    foreach (tv[i]) begin
      while (cyc < tv[i].cyc) step();
      chk("press", 32'(press), 32'(tv[i].exp_press));
      chk("mode",  32'(mode),  32'(tv[i].exp_mode));
      chk("led",   32'(led),   32'(tv[i].exp_led));
      rst = tv[i].rst;
      btn = tv[i].btn;
    end
    chk("press_count_timeline", 32'(press_cnt), 32'd4);

    // Bounce rejection: pattern starts at cycle 82, last low at 86, single pulse at 94.
    p0 = press_cnt;
    for (int k = 0; k <= 14; k++) begin
      while (cyc < 82 + k) step();
      chk("bounce_press", 32'(press), (k == 12) ? 32'd1 : 32'd0);
      btn = (k < 8) ? bpat[k] : 1'b1;
    end
    chk("bounce_mode", 32'(mode), 32'd1);
    chk("bounce_led",  32'(led),  32'd1);
    btn = 1'b0;
    while (cyc < 100) step();
    chk("bounce_count", 32'(press_cnt - p0), 32'd1);

    // Reset mid-debounce: btn high from 106, cnt reaches 2 in cycle 110, rst pulsed then.
    while (cyc < 106) step();
    btn = 1'b1;
    while (cyc < 110) step();
    rst = 1'b1;
    step();
    chk("rstmid_press", 32'(press), 32'd0);
    chk("rstmid_mode",  32'(mode),  32'd0);
    chk("rstmid_led",   32'(led),   32'd0);
    rst = 1'b0;
    for (int c = 112; c <= 120; c++) begin
      while (cyc < c) step();
      chk("rstmid_press_seq", 32'(press), (c == 118) ? 32'd1 : 32'd0);
      if (c == 119) chk("rstmid_mode_after", 32'(mode), 32'd1);
      if (c == 120) chk("rstmid_led_after",  32'(led),  32'd1);
    end
    step();
    step();
    chk("press_count_total", 32'(press_cnt), 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
